parking_session_ctrl: RTL
=========================

Name: parking_session_ctrl

Overview:
- Slot-allocation and session-timing controller for the 4-slot parking lot.
- Sits between the debounced entry/exit buttons and the multiplexed display. It assigns the lowest free slot on entry and times each occupied slot in mm:ss from the 1 Hz tick.
- Sequences the display: capacity by default, then the departing car's parked duration for a fixed hold time after each exit.
- Supplies the occupancy, capacity, location, mode, minutes and seconds signals currently tied off at top level.

Parameters:
- SHOW_SECS, 5, number of tick_1hz pulses the exit duration stays on the display (1..15).
- MAX_MIN, 59, minute value at which a slot timer saturates (timer holds at MAX_MIN:59).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick_1hz  input  1  single-cycle enable, once per second, synchronous to clk.
- entry_req  input  1  debounced entry button, level.
- exit_req  input  1  debounced exit button, level.
- exit_slot  input  2  slot index leaving; sampled on the exit_req rising edge.
- spots  output  4  occupancy bitmap, bit i = slot i occupied.
- capacity  output  3  number of free slots, 0..4.
- location  output  2  lowest-index free slot; 0 when full.
- is_full  output  1  high when spots == 4'b1111.
- entry_ack  output  1  one-cycle pulse: entry accepted.
- entry_rej  output  1  one-cycle pulse: entry refused because the lot is full.
- exit_ack  output  1  one-cycle pulse: exit accepted.
- exit_rej  output  1  one-cycle pulse: exit_slot was not occupied.
- mode  output  1  0 = show capacity, 1 = show duration.
- minutes  output  6  displayed minutes; 0 when mode = 0.
- seconds  output  6  displayed seconds; 0 when mode = 0.

Behaviour:
- Reset values: spots = 0, capacity = 4, location = 0, is_full = 0, all ack/rej = 0, mode = 0, minutes = 0, seconds = 0. All slot timers = 00:00, edge-detect registers = 0, display FSM in SHOW_CAP.
- Reset asserted mid-operation clears everything immediately and asynchronously. A request held high across reset release is not an event; only a fresh 0->1 transition counts.
- Event detection: a registered previous sample of entry_req and exit_req. An event is the clk edge where the input is 1 and the previous sample is 0. Holding a button high produces exactly one event.
- All outputs are registered and reflect an event at that same clk edge (zero extra latency). Ack/rej pulses last exactly one cycle.
- Entry event:
  - If not full: set the bit of the lowest-index free slot, clear that slot's timer to 00:00, pulse entry_ack.
  - If full: pulse entry_rej, no state change.
- Exit event:
  - If spots[exit_slot] = 1: clear the bit, pulse exit_ack, latch that slot's timer value into the display registers, enter SHOW_TIME.
  - If spots[exit_slot] = 0: pulse exit_rej, no other change.
- Simultaneous entry and exit events in the same cycle: both are processed, and entry allocation uses occupancy from before the exit.
  - Consequence: full lot + simultaneous exit -> entry_rej, exit_ack, one slot free afterward.
  - If entry picks the same slot an exit frees, that cannot occur, because an exit slot is occupied and entry picks a free one.
- capacity = 4 - popcount(spots). location = priority encode of ~spots (bit 0 first). Both are derived from the next-state spots so they stay consistent in the same cycle.
- Slot timers: 6-bit minutes plus 6-bit seconds per slot.
  - On tick_1hz, each occupied slot not being allocated this cycle increments.
  - Seconds 59 -> 0 with minutes + 1.
  - At MAX_MIN:59 the timer holds.
  - Free slots hold 00:00.
  - An exit in the same cycle as a tick latches the pre-increment value.
- Display FSM:
  - SHOW_CAP: mode = 0, minutes = seconds = 0.
  - SHOW_TIME: mode = 1, minutes/seconds = latched duration. A 4-bit hold counter is cleared on entry to the state and increments on each tick_1hz. At the edge where the counter reaches SHOW_SECS, the FSM returns to SHOW_CAP.
  - A new accepted exit while in SHOW_TIME reloads the duration and clears the hold counter.
  - exit_rej does not affect the FSM.
  - Entry events do not affect the display state.
- No arithmetic wraps silently: timers saturate, and capacity is always in the range 0..4.

Test Plan:
- Reset, then 4 entry pulses (separated by idle cycles) -> spots 0001, 0011, 0111, 1111; capacity 3, 2, 1, 0; entry_ack each time; is_full = 1 after the 4th; a 5th entry -> entry_rej, spots unchanged.
- Occupy slot 2, apply 65 ticks, exit slot 2 -> exit_ack, mode = 1, minutes = 1, seconds = 5; after 5 further ticks -> mode = 0, minutes = seconds = 0.
- Full lot, entry and exit(slot 1) rising in the same cycle -> entry_rej and exit_ack both pulse, spots = 1101, capacity = 1, location = 1.
- Exit slot 3 with spots = 0001 -> exit_rej only; spots, mode and display unchanged. Then hold entry_req high for 100 cycles -> exactly one entry_ack.
- Occupy slot 0, apply 3600 ticks -> timer saturates at 59:59; on exit the display shows 59:59. A second exit during SHOW_TIME restarts the hold with the new duration.
- Assert reset mid-SHOW_TIME with 3 slots occupied -> all outputs return to reset values immediately; an entry_req held across reset release gives no ack.

Source files
------------

// File: rtl/parking_session_ctrl.sv
// parking_session_ctrl: assigns the lowest free slot on entry, times each occupied slot in mm:ss, and sequences the capacity/duration display.
module parking_session_ctrl #(
  parameter int SHOW_SECS = 5,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  output logic [3:0] spots,
  output logic [2:0] capacity,
  output logic [1:0] location,
  output logic       is_full,
  output logic       entry_ack,
  output logic       entry_rej,
  output logic       exit_ack,
  output logic       exit_rej,
  output logic       mode,
  output logic [5:0] minutes,
  output logic [5:0] seconds
);
  typedef enum logic {SHOW_CAP = 1'b0, SHOW_TIME = 1'b1} disp_t;
  disp_t state_q, state_d;
  logic entry_prev_q, exit_prev_q, entry_arm_q, exit_arm_q;
  logic entry_arm_d, exit_arm_d;
  logic [3:0] spots_q, spots_d;
  logic [2:0] capacity_q, capacity_d;
  logic [1:0] location_q, location_d;
  logic is_full_q, is_full_d;
  logic entry_ack_q, entry_ack_d, entry_rej_q, entry_rej_d;
  logic exit_ack_q, exit_ack_d, exit_rej_q, exit_rej_d;
  logic [5:0] disp_min_q, disp_min_d, disp_sec_q, disp_sec_d;
  logic [3:0] hold_q, hold_d;
  logic [5:0] min_q [4];
  logic [5:0] min_d [4];
  logic [5:0] sec_q [4];
  logic [5:0] sec_d [4];
  logic entry_ev, exit_ev, exit_hit;
  logic [3:0] free, alloc, exit_mask;
  always_comb begin
    // A button only counts once it has been seen low since reset released
    entry_ev = entry_req & ~entry_prev_q & entry_arm_q;
    exit_ev = exit_req & ~exit_prev_q & exit_arm_q;
    entry_arm_d = entry_arm_q | ~entry_req;
    exit_arm_d = exit_arm_q | ~exit_req;
    free = ~spots_q;
    alloc = entry_ev ? (free & (~free + 4'd1)) : 4'd0;
    exit_hit = exit_ev & spots_q[exit_slot];
    exit_mask = exit_hit ? (4'b0001 << exit_slot) : 4'd0;
    spots_d = (spots_q | alloc) & ~exit_mask;
    capacity_d = 3'd4 - ({2'b0, spots_d[0]} + {2'b0, spots_d[1]} + {2'b0, spots_d[2]} + {2'b0, spots_d[3]});
    location_d = !spots_d[0] ? 2'd0 : !spots_d[1] ? 2'd1 : !spots_d[2] ? 2'd2 : !spots_d[3] ? 2'd3 : 2'd0;
    is_full_d = &spots_d;
    entry_ack_d = entry_ev & |free;
    entry_rej_d = entry_ev & ~|free;
    exit_ack_d = exit_hit;
    exit_rej_d = exit_ev & ~spots_q[exit_slot];
    for (int i = 0; i < 4; i++) begin
      min_d[i] = min_q[i];
      sec_d[i] = sec_q[i];
      if (!spots_d[i] || alloc[i]) begin
        min_d[i] = 6'd0;
        sec_d[i] = 6'd0;
      end else if (tick_1hz && !(sec_q[i] == 6'd59 && min_q[i] == 6'(MAX_MIN))) begin
        min_d[i] = (sec_q[i] == 6'd59) ? min_q[i] + 6'd1 : min_q[i];
        sec_d[i] = (sec_q[i] == 6'd59) ? 6'd0 : sec_q[i] + 6'd1;
      end
    end
    state_d = state_q;
    hold_d = hold_q;
    disp_min_d = disp_min_q;
    disp_sec_d = disp_sec_q;
    // Latches the pre-tick value: min_q/sec_q have not yet taken this cycle's increment
    if (exit_hit) begin
      state_d = SHOW_TIME;
      hold_d = 4'd0;
      disp_min_d = min_q[exit_slot];
      disp_sec_d = sec_q[exit_slot];
    end else if (state_q == SHOW_TIME && tick_1hz) begin
      hold_d = (hold_q + 4'd1 == 4'(SHOW_SECS)) ? 4'd0 : hold_q + 4'd1;
      state_d = (hold_q + 4'd1 == 4'(SHOW_SECS)) ? SHOW_CAP : SHOW_TIME;
      disp_min_d = (hold_q + 4'd1 == 4'(SHOW_SECS)) ? 6'd0 : disp_min_q;
      disp_sec_d = (hold_q + 4'd1 == 4'(SHOW_SECS)) ? 6'd0 : disp_sec_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_CAP;
      entry_prev_q <= 1'b0;
      exit_prev_q <= 1'b0;
      entry_arm_q <= 1'b0;
      exit_arm_q <= 1'b0;
      spots_q <= 4'd0;
      capacity_q <= 3'd4;
      location_q <= 2'd0;
      is_full_q <= 1'b0;
      entry_ack_q <= 1'b0;
      entry_rej_q <= 1'b0;
      exit_ack_q <= 1'b0;
      exit_rej_q <= 1'b0;
      disp_min_q <= 6'd0;
      disp_sec_q <= 6'd0;
      hold_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        min_q[i] <= 6'd0;
        sec_q[i] <= 6'd0;
      end
    end else begin
      state_q <= state_d;
      entry_prev_q <= entry_req;
      exit_prev_q <= exit_req;
      entry_arm_q <= entry_arm_d;
      exit_arm_q <= exit_arm_d;
      spots_q <= spots_d;
      capacity_q <= capacity_d;
      location_q <= location_d;
      is_full_q <= is_full_d;
      entry_ack_q <= entry_ack_d;
      entry_rej_q <= entry_rej_d;
      exit_ack_q <= exit_ack_d;
      exit_rej_q <= exit_rej_d;
      disp_min_q <= disp_min_d;
      disp_sec_q <= disp_sec_d;
      hold_q <= hold_d;
      for (int i = 0; i < 4; i++) begin
        min_q[i] <= min_d[i];
        sec_q[i] <= sec_d[i];
      end
    end
  end
  assign spots = spots_q;
  assign capacity = capacity_q;
  assign location = location_q;
  assign is_full = is_full_q;
  assign entry_ack = entry_ack_q;
  assign entry_rej = entry_rej_q;
  assign exit_ack = exit_ack_q;
  assign exit_rej = exit_rej_q;
  assign mode = (state_q == SHOW_TIME);
  assign minutes = disp_min_q;
  assign seconds = disp_sec_q;
endmodule
